// File: rtl/toggle_monitor_if.sv
// toggle_monitor_if: groups the monitored toggle line and the measurement
// results of toggle_monitor.
//   A        monitored toggle line (source -> monitor)
//   LEVEL    synchronised copy of A
//   VALID    one-cycle pulse, HALF_PER updated
//   HALF_PER last measured half-period in CLK cycles
//   LOCKED   monitor is locked onto a running line
//   STALL    no transition seen within the timeout window
// master: the side that drives A and consumes results; slave: the monitor.
interface toggle_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic             A;
  logic             LEVEL;
  logic             VALID;
  logic [CNT_W-1:0] HALF_PER;
  logic             LOCKED;
  logic             STALL;

  modport master (
    output A,
    input  LEVEL, VALID, HALF_PER, LOCKED, STALL
  );

  modport slave (
    input  A,
    output LEVEL, VALID, HALF_PER, LOCKED, STALL
  );
endinterface

// File: rtl/toggle_monitor.sv
// toggle_monitor: far-end receiver for a divided/toggling status line.
// Synchronises A into the CLK domain, detects each transition, measures the
// half-period in CLK cycles and reports lock/stall status.
// Ports:
//   CLK  system clock, rising edge
//   R_N  asynchronous active-low reset
//   bus  toggle_monitor_if.slave (A in; LEVEL, VALID, HALF_PER, LOCKED, STALL out)
// Parameters:
//   CNT_W    width of the cycle counter and HALF_PER
//   TIMEOUT  cycles without a transition before STALL (2 .. 2^CNT_W-1)
module toggle_monitor #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input logic              CLK,
  input logic              R_N,
  toggle_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_LOCK  = 2'd2,
    S_STALL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic             aS1;
  logic             aS2;
  logic             aPrev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] halfPer;
  logic             valid;
  state_t           state;
  state_t           nextState;

  logic edgeSeen;
  logic timeoutHit;
  logic measure;
  logic cntSat;

  assign edgeSeen   = aS2 ^ aPrev;
  assign timeoutHit = (cnt == TO_LAST);
  assign cntSat     = (cnt == CNT_MAX);

  // Next-state logic. An edge always takes priority over the timeout, so a
  // transition landing exactly on the timeout cycle keeps the lock.
  always_comb begin
    nextState = state;
    measure   = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Start point unknown: arm only, no measurement.
        if (edgeSeen) nextState = S_ARM;
      end
      S_ARM, S_LOCK: begin
        if (edgeSeen) begin
          nextState = S_LOCK;
          measure   = 1'b1;
        end else if (timeoutHit) begin
          nextState = S_STALL;
        end
      end
      S_STALL: begin
        // Interval since the previous edge is unbounded: re-arm only.
        if (edgeSeen) nextState = S_ARM;
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      aS1     <= 1'b0;
      aS2     <= 1'b0;
      aPrev   <= 1'b0;
      cnt     <= '0;
      halfPer <= '0;
      valid   <= 1'b0;
      state   <= S_IDLE;
    end else begin
      aS1   <= bus.A;
      aS2   <= aS1;
      aPrev <= aS2;
      state <= nextState;
      valid <= measure;

      // cnt holds cycles elapsed since the last acted edge, saturating.
      if (edgeSeen)    cnt <= '0;
      else if (!cntSat) cnt <= cnt + CNT_ONE;

      // The acting edge cycle itself counts, hence cnt+1.
      if (measure) halfPer <= cntSat ? CNT_MAX : cnt + CNT_ONE;
    end
  end

  assign bus.LEVEL    = aS2;
  assign bus.VALID    = valid;
  assign bus.HALF_PER = halfPer;
  assign bus.LOCKED   = (state == S_LOCK);
  assign bus.STALL    = (state == S_STALL);

endmodule
